// File: rtl/recirculation_mux_sync.sv
// recirculation_mux_sync: pulse-qualified word transfer through a toggle synchronizer and recirculating output mux
module recirculation_mux_sync #(
   parameter int g_width = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_pulse_A,
   input  logic [g_width-1:0] i_data_A,
   output logic [g_width-1:0] o_data_B,
   output logic               f_pulse_B,
   output logic               f_pulse_B_prev
);
   logic [g_width-1:0] data_a_q;
   logic               tog_a, s1, s2, s3;
   assign f_pulse_B = s2 ^ s3;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_a_q       <= '0;
         tog_a          <= 1'b0;
         s1             <= 1'b0;
         s2             <= 1'b0;
         s3             <= 1'b0;
         o_data_B       <= '0;
         f_pulse_B_prev <= 1'b0;
      end else begin
         data_a_q       <= i_pulse_A ? i_data_A : data_a_q;
         tog_a          <= tog_a ^ i_pulse_A;
         s1             <= tog_a;
         s2             <= s1;
         s3             <= s2;
         o_data_B       <= f_pulse_B ? data_a_q : o_data_B;
         f_pulse_B_prev <= f_pulse_B;
      end
   end
endmodule

// File: tb/tb_recirculation_mux_sync.sv
// tb_recirculation_mux_sync: table-driven stimulus with a per-cycle scoreboard of expected strobes and output words
module tb_recirculation_mux_sync;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pulse = 1'b0;
   logic [7:0] data = 8'h00;
   logic [7:0] o_data_b;
   logic       f_pulse_b, f_pulse_b_prev;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       pulse;
      logic [7:0] data;
      int         reps;
      int         idle;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   int         n = 0;
   int         q[$];
   logic [7:0] ecap = 8'h00;
   logic [7:0] eout = 8'h00;
   logic       eprev = 1'b0;
   logic       ef;
   bit         armed = 1'b0;

   recirculation_mux_sync #(.g_width(8)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_pulse_A(pulse),
      .i_data_A(data),
      .o_data_B(o_data_b),
      .f_pulse_B(f_pulse_b),
      .f_pulse_B_prev(f_pulse_b_prev)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, n, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic p, input logic [7:0] d);
      rst = r;
      pulse = p;
      data = d;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each accepted pulse schedules a strobe three cycles later; the strobe loads the latest captured word.
   initial forever begin
      @(negedge clk);
      ef = q.size() > 0 && q[0] == n;
      if (armed) begin
         check("f_pulse_B", {7'd0, f_pulse_b}, {7'd0, ef});
         check("f_pulse_B_prev", {7'd0, f_pulse_b_prev}, {7'd0, eprev});
         check("o_data_B", o_data_b, eout);
      end
      if (rst) begin
         q.delete();
         ecap = 8'h00;
         eout = 8'h00;
         eprev = 1'b0;
         armed = 1'b1;
      end else begin
         eprev = ef;
         if (ef) begin
            eout = ecap;
            void'(q.pop_front());
         end
         if (pulse) begin
            ecap = data;
            q.push_back(n + 3);
         end
      end
      n++;
   end

   initial begin
      vecs.push_back('{1'b1, 1'b1, 8'hFF, 3, 0, 8'h00});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 2, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'hA5, 1, 4, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 8'h01, 1, 3, 8'h01});
      vecs.push_back('{1'b0, 1'b1, 8'h02, 1, 3, 8'h02});
      vecs.push_back('{1'b0, 1'b1, 8'h03, 1, 3, 8'h03});
      vecs.push_back('{1'b0, 1'b1, 8'h11, 1, 0, 8'h03});
      vecs.push_back('{1'b0, 1'b1, 8'h22, 1, 4, 8'h22});
      vecs.push_back('{1'b0, 1'b1, 8'h5A, 1, 1, 8'h22});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 1, 0, 8'h00});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 8, 8'h00});
      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         for (int r = 0; r < vecs[i].reps; r++) drive(vecs[i].rst, vecs[i].pulse, vecs[i].data);
         for (int k = 0; k < vecs[i].idle; k++) drive(1'b0, 1'b0, vecs[i].data);
         check($sformatf("vec%0d_o_data_B", i), o_data_b, vecs[i].exp_data);
         if (i == 2) begin
            for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 8'($urandom));
            check("hold_o_data_B", o_data_b, 8'hA5);
         end
      end
      drive(1'b0, 1'b1, 8'hC3);
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      check("latency_before", o_data_b, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      check("latency_at", o_data_b, 8'hC3);
      check("latency_prev", {7'd0, f_pulse_b_prev}, 8'h01);
      drive(1'b0, 1'b0, 8'h00);
      check("prev_width", {7'd0, f_pulse_b_prev}, 8'h00);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 8'h00);
      check("outstanding_strobes", 8'(q.size()), 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
